// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU with a bit-serial restoring divider.
//
// Every opcode except a divide by a non-zero divisor completes in one cycle:
// the result is computed combinationally from the accepted operands and
// registered on the accepting edge.  A divide with B != 0 moves the block
// into its DIV state, which produces one quotient bit per clock.  After
// IN_WIDTH iterations the block writes {remainder, quotient} and returns
// to IDLE.
//
// Parameters
//   IN_WIDTH  : operand width.
//   OUT_WIDTH : result width.  Must be at least 2*IN_WIDTH.
//   FUN_WIDTH : opcode width (>= 4).  Opcodes above 4'hF produce 0.
//
// Ports
//   CLK       in   clock.  All state changes on the rising edge.
//   RST       in   asynchronous, active-low reset.
//   A, B      in   unsigned operands.
//   ALU_FUN   in   opcode.
//   IN_VALID  in   request strobe.  Ignored while IN_READY is low.
//   IN_READY  out  high in IDLE.  Decoded from state only.
//   ALU_OUT   out  registered result.  Held between results.
//   ALU_VALID out  one-cycle strobe marking a new ALU_OUT/FLAGS.
//   FLAGS     out  {DIV0, CARRY, ZERO}.  Registered together with ALU_OUT.
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16,
  parameter int FUN_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [IN_WIDTH-1:0]  B,
  input  logic [FUN_WIDTH-1:0] ALU_FUN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [OUT_WIDTH-1:0] ALU_OUT,
  output logic                 ALU_VALID,
  output logic [2:0]           FLAGS
);

  localparam int RES_W = 2 * IN_WIDTH;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_NAND = 4'h6,
    OP_NOR  = 4'h7,
    OP_XOR  = 4'h8,
    OP_XNOR = 4'h9,
    OP_EQ   = 4'hA,
    OP_GT   = 4'hB,
    OP_LT   = 4'hC,
    OP_SHR  = 4'hD,
    OP_SHL  = 4'hE,
    OP_ROL  = 4'hF
  } alu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;    // divide iterations completed
  logic [IN_WIDTH-1:0]   rem_q,   rem_d;    // partial remainder
  logic [IN_WIDTH-1:0]   quo_q,   quo_d;    // dividend shifting out, quotient shifting in
  logic [IN_WIDTH-1:0]   dvsr_q,  dvsr_d;   // captured divisor
  logic [OUT_WIDTH-1:0]  out_q,   out_d;
  logic [2:0]            flags_q, flags_d;
  logic                  valid_q, valid_d;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  alu_op_e               op;
  logic                  fun_in_range;
  logic [IN_WIDTH:0]     nar;        // results that fit in IN_WIDTH+1 bits
  logic [RES_W-1:0]      wide;       // MUL and divide-by-zero results
  logic                  use_wide;
  logic [RES_W-1:0]      alu_res;
  logic                  alu_carry;
  logic                  alu_div0;
  logic                  is_long_div;

  assign op           = alu_op_e'(ALU_FUN[3:0]);
  // Opcode bits above [3:0] must all be zero for a defined operation.
  assign fun_in_range = (ALU_FUN >> 4) == '0;
  assign is_long_div  = fun_in_range && (op == OP_DIV) && (B != '0);

  // NOTE: every signal written in an always_comb gets a default at the top,
  // so no path through the case statements can leave it unassigned and infer
  // a latch.
  always_comb begin
    nar       = '0;
    wide      = '0;
    use_wide  = 1'b0;
    alu_carry = 1'b0;
    alu_div0  = 1'b0;
    if (fun_in_range) begin
      case (op)
        OP_ADD: begin
          nar       = {1'b0, A} + {1'b0, B};
          alu_carry = nar[IN_WIDTH];
        end
        OP_SUB: begin
          // The concatenation keeps the difference at IN_WIDTH bits, so the
          // upper bits of the result stay zero.
          nar       = {1'b0, A - B};
          alu_carry = (A < B);
        end
        OP_MUL: begin
          wide     = A * B;  // widened to RES_W by context: full product
          use_wide = 1'b1;
        end
        OP_DIV: begin
          // Only B == 0 reaches the result register from here.  A non-zero
          // divisor goes through the iterative divider instead.
          wide     = {A, {IN_WIDTH{1'b1}}};
          use_wide = 1'b1;
          alu_div0 = 1'b1;
        end
        OP_AND:  nar = {1'b0, A & B};
        OP_OR:   nar = {1'b0, A | B};
        OP_NAND: nar = {1'b0, ~(A & B)};
        OP_NOR:  nar = {1'b0, ~(A | B)};
        OP_XOR:  nar = {1'b0, A ^ B};
        OP_XNOR: nar = {1'b0, ~(A ^ B)};
        OP_EQ:   nar[0]   = (A == B);
        OP_GT:   nar[1]   = (A > B);
        OP_LT:   nar[1:0] = {2{A < B}};
        OP_SHR:  nar = {2'b00, A[IN_WIDTH-1:1]};
        OP_SHL:  nar = {A, 1'b0};
        OP_ROL:  nar = {1'b0, A[IN_WIDTH-2:0], A[IN_WIDTH-1]};
        default: nar = '0;
      endcase
    end
    alu_res = use_wide ? wide : RES_W'(nar);
  end

  // ---------------------------------------------------------------------------
  // Restoring divide step
  //   Shift the next dividend bit into the partial remainder.  If the divisor
  //   fits, subtract it and emit a 1.  Otherwise keep the shifted remainder
  //   (the "restore") and emit a 0.
  // ---------------------------------------------------------------------------
  logic [IN_WIDTH:0]     shifted;
  logic [IN_WIDTH-1:0]   rem_sub;
  logic                  fits;
  logic [IN_WIDTH-1:0]   rem_nxt;
  logic [IN_WIDTH-1:0]   quo_nxt;
  logic [RES_W-1:0]      div_res;

  always_comb begin
    shifted = {rem_q, quo_q[IN_WIDTH-1]};
    fits    = (shifted >= {1'b0, dvsr_q});
    // When the divisor fits, the true difference is below the divisor.
    // An IN_WIDTH-bit subtraction is therefore exact.
    rem_sub = shifted[IN_WIDTH-1:0] - dvsr_q;
    rem_nxt = fits ? rem_sub : shifted[IN_WIDTH-1:0];
    quo_nxt = {quo_q[IN_WIDTH-2:0], fits};
    div_res = {rem_nxt, quo_nxt};
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    out_d   = out_q;
    flags_d = flags_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          if (is_long_div) begin
            state_d = S_DIV;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = A;
            dvsr_d  = B;
          end else begin
            out_d   = OUT_WIDTH'(alu_res);
            flags_d = {alu_div0, alu_carry, (alu_res == '0)};
            valid_d = 1'b1;
          end
        end
      end

      S_DIV: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        // The last iteration writes its result directly.  IN_READY returns
        // in the same cycle that ALU_VALID is raised.
        if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
          state_d = S_IDLE;
          out_d   = OUT_WIDTH'(div_res);
          flags_d = {1'b0, 1'b0, (div_res == '0)};
          valid_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  // This way every flop samples the values from before the edge, whatever
  // order the simulator evaluates the blocks in.
  // NOTE: the divider datapath registers are reset along with the control
  // state.  An aborted divide then leaves no stale operands behind, and the
  // reset state is fully defined.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      out_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign ALU_OUT   = out_q;
  assign ALU_VALID = valid_q;
  assign FLAGS     = flags_q;

endmodule
